// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg
//   Shared types and elaboration-time helpers for the serial shift-chain
//   transmitter (piso_serializer) and its reusable bit counter.
//   - state_t    : FSM state encoding (IDLE, SHIFT)
//   - frame_len  : bits per frame (data bits plus optional parity bit)
//   - cnt_width  : counter width able to hold any frame bit index
package piso_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int unsigned frame_len(input int unsigned width,
                                            input int unsigned parity_en);
    return width + ((parity_en != 0) ? 1 : 0);
  endfunction

  // $clog2(width+1) leaves room for index width (the parity bit position).
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter
//   Loadable down-counter shared by the serializer and the receive-side
//   deserializer. It tracks the index of the bit currently on the line.
//   Ports:
//     clock       rising-edge clock
//     reset_n     asynchronous active-low reset (value -> 0)
//     load        load load_value (has priority over enable)
//     enable      decrement by one
//     load_value  value loaded at the start of a frame
//     value       current count
//     is_first    value equals FIRST_VALUE (first bit of a frame)
//     is_last     value equals zero (last bit of a frame)
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int unsigned CW          = cnt_width(8),
  parameter int unsigned FIRST_VALUE = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          enable,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          is_first,
  output logic          is_last
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (enable) begin
      value <= value - 1'b1;
    end
  end

  always_comb begin
    is_first = (value == CW'(FIRST_VALUE));
    is_last  = (value == '0);
  end

endmodule

// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out transmitter. A WIDTH-bit word is accepted
//   through a valid/ready handshake and sent one bit per clock on
//   shift_out, optionally followed by an even-parity bit. Frame markers
//   let the far end align words without its own bit counter.
//   Parameters:
//     WIDTH      data word width (>= 2)
//     MSB_FIRST  1 = bit WIDTH-1 first, 0 = bit 0 first
//     PARITY_EN  1 = append an even-parity bit after the data
//   Ports:
//     clock        rising-edge clock
//     reset_n      asynchronous active-low reset
//     data_in      parallel word, sampled only on the accept edge
//     data_valid   data_in valid this cycle
//     data_ready   word can be accepted this cycle (from state/counter only)
//     shift_out    serial data bit (0 when no frame is on the line)
//     frame_valid  shift_out carries a frame bit
//     frame_start  first bit of a frame on shift_out
//     frame_last   last bit (data or parity) of a frame on shift_out
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned PARITY_EN = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             shift_out,
  output logic             frame_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int unsigned FL = frame_len(WIDTH, PARITY_EN);
  localparam int unsigned CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(FL - 1);

  state_t          state;
  state_t          state_next;
  logic [FL-1:0]   sr;
  logic [FL-1:0]   sr_next;
  logic [FL-1:0]   load_word;
  logic [CW-1:0]   cnt;
  logic            cnt_first;
  logic            cnt_last;
  logic            cnt_en;
  logic            accept;
  logic            parity;
  logic            head_next;
  logic            last_next;

  piso_bit_counter #(
    .CW          (CW),
    .FIRST_VALUE (FL - 1)
  ) u_bit_counter (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (accept),
    .enable     (cnt_en),
    .load_value (LAST_IDX),
    .value      (cnt),
    .is_first   (cnt_first),
    .is_last    (cnt_last)
  );

  // Ready in IDLE and on the last bit of a frame, giving gap-free
  // back-to-back frames. Never depends on data_valid.
  always_comb begin
    data_ready = (state == IDLE) || ((state == SHIFT) && cnt_last);
    accept     = data_valid && data_ready;
  end

  // Frame image as loaded into the shift register. The parity bit sits at
  // the tail end relative to the shift direction so it leaves after the
  // data bits. XOR of the data makes the frame's total ones count even.
  always_comb begin
    parity    = ^data_in;
    load_word = '0;
    if (MSB_FIRST != 0) begin
      load_word[FL-1 -: WIDTH] = data_in;
      if (PARITY_EN != 0) begin
        load_word[0] = parity;
      end
    end else begin
      load_word[WIDTH-1:0] = data_in;
      if (PARITY_EN != 0) begin
        load_word[FL-1] = parity;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sr    <= '0;
    end else begin
      state <= state_next;
      sr    <= sr_next;
    end
  end

  always_comb begin
    state_next = state;
    sr_next    = sr;
    cnt_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sr_next    = load_word;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          sr_next = load_word;
        end else if (cnt_last) begin
          sr_next    = '0;
          state_next = IDLE;
        end else begin
          cnt_en = 1'b1;
          if (MSB_FIRST != 0) begin
            sr_next = {sr[FL-2:0], 1'b0};
          end else begin
            sr_next = {1'b0, sr[FL-1:1]};
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output flops are computed from next-cycle values so the markers and
  // line bit are plain registers. A reload always starts at index FL-1
  // (never 0 because FL >= 2); otherwise the next bit is last when the
  // counter is about to step from 1 to 0.
  always_comb begin
    head_next = (MSB_FIRST != 0) ? sr_next[FL-1] : sr_next[0];
    last_next = (state_next == SHIFT) && !accept && (cnt == CW'(1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_out   <= 1'b0;
      frame_valid <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      shift_out   <= (state_next == SHIFT) && head_next;
      frame_valid <= (state_next == SHIFT);
      frame_start <= accept;
      frame_last  <= last_next;
    end
  end

  // The registered markers must agree with the counter decode.
  assert property (@(posedge clock) disable iff (!reset_n)
    (state == SHIFT) |-> ((frame_start == cnt_first) && (frame_last == cnt_last)));

endmodule

// File: tb/tb_piso_serializer.sv
module tb_piso_serializer;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       rdy [3];
  logic       so  [3];
  logic       fv  [3];
  logic       fs  [3];
  logic       fl  [3];

  int errors = 0;
  int checks = 0;

  localparam int MSBF [3] = '{1, 0, 1};
  localparam int PARE [3] = '{0, 0, 1};

  always #5 clock = ~clock;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
    .clock(clock), .reset_n(reset_n), .data_in(din[0]), .data_valid(dv[0]),
    .data_ready(rdy[0]), .shift_out(so[0]), .frame_valid(fv[0]),
    .frame_start(fs[0]), .frame_last(fl[0]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY_EN(0)) u1 (
    .clock(clock), .reset_n(reset_n), .data_in(din[1]), .data_valid(dv[1]),
    .data_ready(rdy[1]), .shift_out(so[1]), .frame_valid(fv[1]),
    .frame_start(fs[1]), .frame_last(fl[1]));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY_EN(1)) u2 (
    .clock(clock), .reset_n(reset_n), .data_in(din[2]), .data_valid(dv[2]),
    .data_ready(rdy[2]), .shift_out(so[2]), .frame_valid(fv[2]),
    .frame_start(fs[2]), .frame_last(fl[2]));

  // ---------------- reference model: queue of bits still to appear on the line
  bit exp_q  [3][$];
  bit exp_st [3];
  bit m_acc;

  function automatic void build_frame(int k, logic [7:0] d);
    for (int i = 0; i < 8; i++) exp_q[k].push_back((MSBF[k] != 0) ? d[7-i] : d[i]);
    if (PARE[k] != 0) exp_q[k].push_back(^d);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        exp_q[k].delete();
        exp_st[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        m_acc = dv[k] && (exp_q[k].size() <= 1);
        if (exp_q[k].size() > 0) void'(exp_q[k].pop_front());
        exp_st[k] = m_acc;
        if (m_acc) build_frame(k, din[k]);
      end
    end
  end

  task automatic chk(string name, int k, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t: got %b, want %b", name, k, $time, act, exp);
    end
  endtask

  // ---------------- per-cycle compare, plus line capture for literal checks
  bit cap       [3][$];
  int cap_start [3];
  int cap_last  [3];
  int run_len   [3];
  int max_run   [3];
  logic e_fv, e_so, e_fs, e_fl, e_rdy;

  always @(negedge clock) begin
    for (int k = 0; k < 3; k++) begin
      e_fv  = exp_q[k].size() > 0;
      e_so  = e_fv ? exp_q[k][0] : 1'b0;
      e_fs  = e_fv && exp_st[k];
      e_fl  = exp_q[k].size() == 1;
      e_rdy = exp_q[k].size() <= 1;
      chk("frame_valid", k, fv[k], e_fv);
      chk("shift_out",   k, so[k], e_so);
      chk("frame_start", k, fs[k], e_fs);
      chk("frame_last",  k, fl[k], e_fl);
      chk("data_ready",  k, rdy[k], e_rdy);
      if (fv[k] === 1'b1) begin
        if (fs[k] === 1'b1 && cap_start[k] < 0) cap_start[k] = cap[k].size();
        if (fl[k] === 1'b1) cap_last[k] = cap[k].size();
        cap[k].push_back(so[k]);
        run_len[k]++;
        if (run_len[k] > max_run[k]) max_run[k] = run_len[k];
      end else begin
        run_len[k] = 0;
      end
    end
  end

  task automatic clear_cap(int k);
    cap[k].delete();
    cap_start[k] = -1;
    cap_last[k]  = -1;
    max_run[k]   = 0;
  endtask

  task automatic check_cap(string name, int k, int n, logic [31:0] exp, int st, int la);
    logic [31:0] val;
    val = '0;
    foreach (cap[k][i]) val = {val[30:0], cap[k][i]};
    checks++;
    if (cap[k].size() != n) begin
      errors++;
      $display("FAIL %s_len: got %0d bits, want %0d", name, cap[k].size(), n);
    end
    checks++;
    if (val !== exp) begin
      errors++;
      $display("FAIL %s_bits: got %h, want %h", name, val, exp);
    end
    checks++;
    if (cap_start[k] != st) begin
      errors++;
      $display("FAIL %s_start_pos: got %0d, want %0d", name, cap_start[k], st);
    end
    checks++;
    if (cap_last[k] != la) begin
      errors++;
      $display("FAIL %s_last_pos: got %0d, want %0d", name, cap_last[k], la);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(int k, logic [7:0] d);
    int n;
    n = 0;
    din[k] = d;
    dv[k]  = 1'b1;
    while (exp_q[k].size() > 1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout[%0d]: got no ready in %0d cycles, want ready", k, n);
    end
    @(posedge clock);
    @(negedge clock);
    dv[k] = 1'b0;
  endtask

  task automatic wait_idle(int k);
    int n;
    n = 0;
    while (exp_q[k].size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout[%0d]: got busy after %0d cycles, want idle", k, n);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      din[k] = '0;
      dv[k]  = 1'b0;
      run_len[k] = 0;
      clear_cap(k);
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_shift_out",   k, so[k], 1'b0);
      chk("rst_frame_valid", k, fv[k], 1'b0);
      chk("rst_frame_start", k, fs[k], 1'b0);
      chk("rst_frame_last",  k, fl[k], 1'b0);
    end
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    for (int k = 0; k < 3; k++) chk("ready_after_reset", k, rdy[k], 1'b1);

    // MSB first, 0xA5
    clear_cap(0);
    send(0, 8'hA5);
    wait_idle(0);
    check_cap("a5_msb", 0, 8, 32'h0000_00A5, 0, 7);

    // LSB first: 0xA5 is bit-symmetric, 0x01 sends its 1 first
    clear_cap(1);
    send(1, 8'hA5);
    wait_idle(1);
    check_cap("a5_lsb", 1, 8, 32'h0000_00A5, 0, 7);
    clear_cap(1);
    send(1, 8'h01);
    wait_idle(1);
    check_cap("01_lsb", 1, 8, 32'h0000_0080, 0, 7);

    // Parity: 0xA5 -> trailing 0, 0x07 -> trailing 1, last marker on parity bit
    clear_cap(2);
    send(2, 8'hA5);
    wait_idle(2);
    check_cap("a5_par", 2, 9, 32'h0000_014A, 0, 8);
    clear_cap(2);
    send(2, 8'h07);
    wait_idle(2);
    check_cap("07_par", 2, 9, 32'h0000_000F, 0, 8);

    // Back-to-back words with data_valid held high
    clear_cap(0);
    send(0, 8'h3C);
    send(0, 8'hC3);
    send(0, 8'hFF);
    wait_idle(0);
    checks++;
    if (max_run[0] != 24) begin
      errors++;
      $display("FAIL b2b_contiguous: got %0d cycles, want 24", max_run[0]);
    end
    check_cap("b2b", 0, 24, 32'h003C_C3FF, 0, 23);

    // Mid-frame valid pulse with changing data is ignored
    clear_cap(0);
    send(0, 8'h5A);
    repeat (2) @(negedge clock);
    chk("busy_not_ready", 0, rdy[0], 1'b0);
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    @(negedge clock);
    dv[0]  = 1'b0;
    din[0] = 8'h00;
    wait_idle(0);
    check_cap("ignore_pulse", 0, 8, 32'h0000_005A, 0, 7);

    // Asynchronous reset on bit 4 of 0xF0, then a clean 0x81
    clear_cap(0);
    send(0, 8'hF0);
    repeat (3) @(negedge clock);
    chk("pre_abort_valid", 0, fv[0], 1'b1);
    chk("pre_abort_bit4",  0, so[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_shift_out",   0, so[0], 1'b0);
    chk("abort_frame_valid", 0, fv[0], 1'b0);
    chk("abort_frame_start", 0, fs[0], 1'b0);
    chk("abort_frame_last",  0, fl[0], 1'b0);
    chk("abort_ready",       0, rdy[0], 1'b1);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("ready_after_abort", 0, rdy[0], 1'b1);
    clear_cap(0);
    send(0, 8'h81);
    wait_idle(0);
    check_cap("81_after_abort", 0, 8, 32'h0000_0081, 0, 7);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out transmitter that accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on shift_out. An optional even-parity bit is appended. It is the transmit end of the team's serial shift chains: its shift_out feeds the serial input of a downstream shift register or deserializer. Frame markers let the far end align words without a separate bit counter.

## Interface
- WIDTH, 8, data word width in bits (≥2)
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- data_in  input  WIDTH  parallel word to transmit
- data_valid  input  1  data_in is valid this cycle
- data_ready  output  1  block can accept a word this cycle
- shift_out  output  1  serial data bit
- frame_valid  output  1  shift_out carries a frame bit this cycle
- frame_start  output  1  first bit of a frame is on shift_out
- frame_last  output  1  last bit (data or parity) of a frame is on shift_out

## Operation
- The clock is named clock. Reset is asynchronous and active-low, on reset_n.
- FRAME_LEN = WIDTH + PARITY_EN bits.
- The FSM has two states, IDLE and SHIFT.
- IDLE:
  - data_ready = 1.
  - On an accept (data_valid & data_ready at a rising edge), load data_in into the shift register and the counter with FRAME_LEN-1, then go to SHIFT.
- SHIFT:
  - shift_out presents the current head bit and frame_valid = 1.
  - Each edge shifts the register by one bit (left if MSB_FIRST, else right) and decrements the counter.
  - frame_start = 1 when the counter equals FRAME_LEN-1. frame_last = 1 when the counter equals 0.
  - data_ready = frame_last, which allows back-to-back frames.
- On the edge that ends the last bit:
  - An accept reloads the register and stays in SHIFT.
  - Otherwise the FSM returns to IDLE.
- Parity:
  - The parity bit is computed at load time as the XOR of all data_in bits and stored alongside the data.
  - It goes out after the data bits, so the total number of ones in the frame is even.
- When frame_valid = 0, shift_out = 0. Idle-line value is 0.
- data_in is sampled only at the accept edge. Later changes to it have no effect on the frame in flight.
- data_valid while data_ready = 0 is ignored. No error is flagged and nothing is stored. The upstream block must hold its word until it sees data_ready.
- Reset mid-frame aborts the frame immediately. Outputs take their reset values and the partially sent word is discarded.

## Timing
- Reset values: shift_out = 0, frame_valid = 0, frame_start = 0, frame_last = 0, state = IDLE.
- data_ready reads 1 after reset is released.
- data_ready is combinational from state and counter. It must not depend on data_valid.
- Latency: the first bit appears on shift_out in the cycle after the accept edge.
- A frame occupies exactly FRAME_LEN consecutive cycles with frame_valid = 1.
- Back-to-back accepts give continuous frame_valid with no gap. frame_last of frame N is immediately followed by frame_start of frame N+1.
- With a single accept, frame_valid falls in the cycle after frame_last.
- shift_out, frame_valid, frame_start and frame_last are registered outputs (no combinational path from inputs).
- Throughput: one word per FRAME_LEN cycles maximum.

## Structure
- Shared package piso_serializer_pkg holds:
  - the state enum (IDLE, SHIFT);
  - the localparam function for FRAME_LEN;
  - the counter width, $clog2(WIDTH+1).
- Sub-module piso_bit_counter:
  - loadable down-counter with load, enable and value ports;
  - is_first and is_last flags.
  - The deserializer on the receive side reuses it.
- The top level holds the FSM, the shift register (FRAME_LEN bits, parity included) and the output registers.

## Test plan
- Reset, WIDTH=8, MSB_FIRST=1, PARITY_EN=0, accept 0xA5 -> shift_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting the cycle after accept; frame_start on bit 1, frame_last on bit 8; frame_valid falls after.
- MSB_FIRST=0, accept 0xA5 -> shift_out 1,0,1,0,0,1,0,1 (LSB first, same pattern because 0xA5 is bit-symmetric); repeat with 0x01 -> 1,0,0,0,0,0,0,0.
- PARITY_EN=1, accept 0xA5 -> 9-bit frame ending in parity 0; accept 0x07 -> parity bit 1; frame_last on the parity bit.
- data_valid held high with words 0x3C, 0xC3, 0xFF -> 24 contiguous frame_valid cycles; data_ready high only in IDLE and on each frame_last; every word is transmitted in order and none is lost.
- Assert reset_n low on bit 4 of 0xF0 -> outputs go to 0 immediately (asynchronous); after release data_ready = 1 and a new accept of 0x81 transmits cleanly.
- data_valid pulsed mid-frame with data_in changing -> pulse ignored; the current frame's bits are unchanged.
